// File: rtl/fiber_link_pkg.sv
// Shared definitions for the fiber command link: frame layout, FSM encoding
// and the parity rule used by both the transmit and receive sides.
package fiber_link_pkg;

  localparam int unsigned CMD_BITS        = 4;
  localparam int unsigned DATA_BITS_SIZES = CMD_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } fiber_state_e;

  // Payload as it sits in the shift register, MSB sent first.
  typedef struct packed {
    logic [CMD_BITS-1:0] cmd;
    logic                parity;
  } fiber_payload_t;

  function automatic logic cmd_parity(input logic [CMD_BITS-1:0] cmd);
    return ^cmd;
  endfunction

endpackage

// File: rtl/fiber_frame_tx_if.sv
// Command request / serial line bundle between a command source and the
// fiber frame transmitter.
interface fiber_frame_tx_if;
  import fiber_link_pkg::*;

  logic [CMD_BITS-1:0] tx_data;
  logic                tx_req;
  logic                parity_inv;
  logic                tx_busy;
  logic                tx_done;
  logic                fiber_tx;

  modport master (
    output tx_data, tx_req, parity_inv,
    input  tx_busy, tx_done, fiber_tx
  );

  modport slave (
    input  tx_data, tx_req, parity_inv,
    output tx_busy, tx_done, fiber_tx
  );

endinterface

// File: rtl/fiber_bit_timer.sv
// Bit-period timer: counts 1 us ticks and flags the tick that ends a bit.
module fiber_bit_timer #(
  parameter int unsigned BIT_US = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clr,
  output logic bit_end_c
);

  localparam int unsigned TMR_W = (BIT_US > 1) ? $clog2(BIT_US) : 1;

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             at_last_c;

  assign at_last_c = (cnt_q == TMR_W'(BIT_US - 1));
  // Clear wins over a coincident tick so a load-cycle tick is never counted.
  assign bit_end_c = tick && !clr && at_last_c;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = at_last_c ? '0 : cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fiber_frame_tx.sv
// Fiber command frame transmitter: start, 4 command bits MSB first, parity,
// stop, then an idle-high gap before the next frame may start.
module fiber_frame_tx
  import fiber_link_pkg::fiber_state_e, fiber_link_pkg::fiber_payload_t,
         fiber_link_pkg::cmd_parity, fiber_link_pkg::ST_IDLE,
         fiber_link_pkg::ST_START, fiber_link_pkg::ST_DATA,
         fiber_link_pkg::ST_STOP, fiber_link_pkg::ST_GAP;
#(
  parameter int unsigned DATA_BITS_SIZES = fiber_link_pkg::DATA_BITS_SIZES,
  parameter int unsigned BIT_US          = 2,
  parameter int unsigned IDLE_BITS       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              time_1us,
  fiber_frame_tx_if.slave   bus
);

  localparam int unsigned IDX_MAX = (DATA_BITS_SIZES > IDLE_BITS) ? DATA_BITS_SIZES : IDLE_BITS;
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
  localparam int unsigned MSB     = DATA_BITS_SIZES - 1;

  fiber_state_e               state_q, state_d;
  logic [DATA_BITS_SIZES-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       fiber_q, fiber_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       bit_end_c;
  logic                       tmr_clr_c;
  logic                       start_c;
  fiber_payload_t             payload_c;

  assign tmr_clr_c = (state_q == ST_IDLE);

  fiber_bit_timer #(.BIT_US(BIT_US)) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (time_1us),
    .clr       (tmr_clr_c),
    .bit_end_c (bit_end_c)
  );

  always_comb begin
    payload_c.cmd    = bus.tx_data;
    payload_c.parity = cmd_parity(bus.tx_data) ^ bus.parity_inv;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    fiber_d = fiber_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    start_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        fiber_d = 1'b1;
        busy_d  = 1'b0;
        start_c = bus.tx_req;
      end
      ST_START: begin
        if (bit_end_c) begin
          state_d = ST_DATA;
          idx_d   = '0;
          fiber_d = shreg_q[MSB];
          shreg_d = shreg_q << 1;
        end
      end
      ST_DATA: begin
        if (bit_end_c) begin
          if (idx_q == IDX_W'(DATA_BITS_SIZES - 1)) begin
            state_d = ST_STOP;
            fiber_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            fiber_d = shreg_q[MSB];
            shreg_d = shreg_q << 1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end_c) begin
          done_d = 1'b1;
          idx_d  = '0;
          if (IDLE_BITS > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            start_c = bus.tx_req;
          end
        end
      end
      ST_GAP: begin
        if (bit_end_c) begin
          if (idx_q == IDX_W'(IDLE_BITS - 1)) begin
            // Gap end is the IDLE boundary; a held request chains straight in.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            start_c = bus.tx_req;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        fiber_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (start_c) begin
      state_d = ST_START;
      shreg_d = DATA_BITS_SIZES'(payload_c);
      idx_d   = '0;
      fiber_d = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      fiber_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      fiber_q <= fiber_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.fiber_tx = fiber_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_fiber_frame_tx.sv
// Directed bench for fiber_frame_tx with BIT_US=2, IDLE_BITS=2 and a 1 us
// tick every 4 clk, so every bit is 8 clk once loads are tick-aligned.
module tb_fiber_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       time_1us = 1'b0;
  logic [1:0] div = 2'd0;
  int         total = 0;
  int         bad = 0;

  fiber_frame_tx_if bus();

  fiber_frame_tx #(.BIT_US(2), .IDLE_BITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_1us (time_1us),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // One-clk tick every 4 clk, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    div      = div + 2'd1;
    time_1us = (div == 2'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stop at a negedge whose following posedge carries a tick.
  task automatic align();
    int n = 0;
    @(negedge clk);
    while (time_1us !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("align", 8'(time_1us), 8'd1);
  endtask

  // One frame: offset 0 is the first negedge after the load edge.
  task automatic run_frame(input string name, input logic [3:0] d, input logic inv,
                           input logic [6:0] exp_bits, input logic exp_perr,
                           input int inj_at);
    logic [6:0] rx = '0;
    logic       perr;
    align();
    bus.tx_data    = d;
    bus.parity_inv = inv;
    bus.tx_req     = 1'b1;
    for (int off = 0; off <= 72; off++) begin
      @(negedge clk);
      if (off == 0) begin
        bus.tx_req     = 1'b0;
        bus.tx_data    = ~d;
        bus.parity_inv = ~inv;
        chk({name, "_load_line"}, 8'(bus.fiber_tx), 8'd0);
        chk({name, "_load_busy"}, 8'(bus.tx_busy), 8'd1);
      end
      if (off < 56 && off % 8 == 4) begin
        rx[6 - off / 8] = bus.fiber_tx;
        chk($sformatf("%s_bit%0d", name, off / 8), 8'(bus.fiber_tx), 8'(exp_bits[6 - off / 8]));
      end
      if (off == 55) chk({name, "_done_pre"},  8'(bus.tx_done), 8'd0);
      if (off == 56) chk({name, "_done"},      8'(bus.tx_done), 8'd1);
      if (off == 57) chk({name, "_done_post"}, 8'(bus.tx_done), 8'd0);
      if (off == 64) chk({name, "_gap_line"},  8'(bus.fiber_tx), 8'd1);
      if (off == 71) chk({name, "_busy_gap"},  8'(bus.tx_busy), 8'd1);
      if (off == 72) chk({name, "_busy_drop"}, 8'(bus.tx_busy), 8'd0);
      if (inj_at > 0 && off == inj_at) begin
        bus.tx_req  = 1'b1;
        bus.tx_data = 4'b0001;
      end
      if (inj_at > 0 && off == inj_at + 1) bus.tx_req = 1'b0;
    end
    perr = (rx[5] ^ rx[4] ^ rx[3] ^ rx[2]) != rx[1];
    chk({name, "_parity_err"}, 8'(perr), 8'(exp_perr));
  endtask

  initial begin
    int lows;
    int dones;
    int busys;

    bus.tx_req     = 1'b0;
    bus.tx_data    = 4'h0;
    bus.parity_inv = 1'b0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line", 8'(bus.fiber_tx), 8'd1);
    chk("rst_busy", 8'(bus.tx_busy),  8'd0);
    chk("rst_done", 8'(bus.tx_done),  8'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_line", 8'(bus.fiber_tx), 8'd1);

    // start d3 d2 d1 d0 P stop
    run_frame("f1010",   4'b1010, 1'b0, 7'b0101001, 1'b0, 0);
    run_frame("f0111",   4'b0111, 1'b0, 7'b0011111, 1'b0, 0);
    run_frame("f0111i",  4'b0111, 1'b1, 7'b0011101, 1'b1, 0);
    run_frame("fignore", 4'b1010, 1'b0, 7'b0101001, 1'b0, 20);

    lows  = 0;
    busys = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.fiber_tx !== 1'b1) lows++;
      if (bus.tx_busy !== 1'b0) busys++;
    end
    chk("ignore_no_frame", 8'(lows),  8'd0);
    chk("ignore_no_busy",  8'(busys), 8'd0);

    // Held request: second start bit exactly 16 clk after the stop-bit end.
    align();
    bus.tx_data    = 4'hF;
    bus.parity_inv = 1'b0;
    bus.tx_req     = 1'b1;
    lows = 0;
    for (int off = 0; off <= 144; off++) begin
      logic [6:0] expf;
      expf = 7'b0111101;
      @(negedge clk);
      if (off == 0) chk("hold_load_line", 8'(bus.fiber_tx), 8'd0);
      if (off < 56 && off % 8 == 4)
        chk($sformatf("hold_a_bit%0d", off / 8), 8'(bus.fiber_tx), 8'(expf[6 - off / 8]));
      if (off == 56) chk("hold_a_done", 8'(bus.tx_done), 8'd1);
      if (off >= 56 && off <= 71 && bus.fiber_tx !== 1'b1) lows++;
      if (off == 72) begin
        chk("hold_gap_high", 8'(lows), 8'd0);
        chk("hold_b_start",  8'(bus.fiber_tx), 8'd0);
        chk("hold_b_busy",   8'(bus.tx_busy), 8'd1);
      end
      if (off == 80) bus.tx_req = 1'b0;
      if (off >= 72 && off < 128 && (off - 72) % 8 == 4)
        chk($sformatf("hold_b_bit%0d", (off - 72) / 8), 8'(bus.fiber_tx), 8'(expf[6 - (off - 72) / 8]));
      if (off == 128) chk("hold_b_done", 8'(bus.tx_done), 8'd1);
      if (off == 144) begin
        chk("hold_end_busy", 8'(bus.tx_busy),  8'd0);
        chk("hold_end_line", 8'(bus.fiber_tx), 8'd1);
      end
    end

    // Reset during d1 (offsets 24..31) of an all-zero command.
    align();
    bus.tx_data    = 4'b0000;
    bus.parity_inv = 1'b0;
    bus.tx_req     = 1'b1;
    for (int off = 0; off <= 26; off++) begin
      @(negedge clk);
      if (off == 0) bus.tx_req = 1'b0;
    end
    chk("pre_rst_line", 8'(bus.fiber_tx), 8'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_line", 8'(bus.fiber_tx), 8'd1);
    chk("async_rst_busy", 8'(bus.tx_busy),  8'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    dones = 0;
    busys = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.fiber_tx !== 1'b1) lows++;
      if (bus.tx_done !== 1'b0) dones++;
      if (bus.tx_busy !== 1'b0) busys++;
    end
    chk("post_rst_no_line", 8'(lows),  8'd0);
    chk("post_rst_no_done", 8'(dones), 8'd0);
    chk("post_rst_no_busy", 8'(busys), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fiber_frame_tx.md
FIBER_FRAME_TX -- requirements
Module: fiber_frame_tx

Interface
REQ-001 Parameter DATA_BITS_SIZES, default 5: frame payload width, 4 command bits plus 1 parity bit.
REQ-002 Parameter BIT_US, default 2: bit period as a count of time_1us ticks; legal range 1..255.
REQ-003 Parameter IDLE_BITS, default 2: minimum idle-high gap after the stop bit, in bit periods; legal range 0..15.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 time_1us  input  1  one-clk pulse every 1 us.
REQ-007 tx_data  input  4  command nibble to send.
REQ-008 tx_req  input  1  level request; sampled only in IDLE.
REQ-009 parity_inv  input  1  test hook; when high at load, the transmitted parity bit is inverted.
REQ-010 tx_busy  output  1  high from load until the idle gap ends.
REQ-011 tx_done  output  1  one-clk pulse when the stop bit completes.
REQ-012 fiber_tx  output  1  serial line; idles high.

Function
REQ-013 Frame on the line shall be: start(0), d3, d2, d1, d0, P, stop(1), then the idle gap; P = d3^d2^d1^d0 (XOR of the nibble), inverted if parity_inv was high at load.
REQ-014 A receiver that reassembles the frame as {d3,d2,d1,d0,P} shall see bits[4]^[3]^[2]^[1] == bit[0] for every non-inverted frame.
REQ-015 States: IDLE, START, DATA, STOP, GAP.
REQ-016 IDLE: fiber_tx=1 and tx_busy=0; tx_req=1 on a clk edge shall latch tx_data, latch the computed P into a 5-bit shift register, clear the bit timer and bit index, and enter START.
REQ-017 From that same edge, fiber_tx=0 and tx_busy=1 (1 clk latency from tx_req).
REQ-018 Bit timer counts time_1us ticks only; a bit ends on the tick at which timer==BIT_US-1, and the timer then clears.
REQ-019 Each bit shall last exactly BIT_US ticks.
REQ-020 START->DATA at bit end.
REQ-021 DATA: shift MSB first; bit index 0..4; DATA->STOP after index 4 ends.
REQ-022 STOP: fiber_tx=1; at bit end, pulse tx_done for exactly 1 clk.
REQ-023 At STOP bit end, enter GAP if IDLE_BITS>0, else enter IDLE.
REQ-024 GAP: fiber_tx=1 and tx_busy=1; return to IDLE after IDLE_BITS bit periods.
REQ-025 tx_req, tx_data and parity_inv shall be ignored outside IDLE; there is no queueing.
REQ-026 A tx_req held high shall produce back-to-back frames separated by exactly IDLE_BITS bit periods of high line.
REQ-027 A time_1us pulse on the same clk as the load shall not be counted toward the start bit.
REQ-028 Bit index and timer widths shall be sized from the parameters; no wrap-around shall occur within legal ranges.
REQ-029 fiber_tx shall be driven directly from a flop, with no glitches.

Reset
REQ-030 When rst_n=0, the block shall be forced to IDLE: fiber_tx=1, tx_busy=0, tx_done=0, shift register, timer and index all 0.
REQ-031 Reset asserted mid-frame shall abort the frame immediately (asynchronously).
REQ-032 After rst_n rises, a frame shall not start until a fresh tx_req is sampled.

Structure
REQ-033 The state encoding, DATA_BITS_SIZES, and a parity function shared with the receive side shall live in package fiber_link_pkg.
REQ-034 A single sub-module, fiber_bit_timer (tick counter with bit_end output and clear input), is natural.
REQ-035 The state machine and shift register shall remain in the top module.

Verification (BIT_US=2, IDLE_BITS=2, time_1us every 4 clk)
REQ-036 Send tx_data=4'b1010 -> fiber_tx reads 0,1,0,1,0,0,1, each bit 8 clk long; tx_done pulses 1 clk at the stop-bit end; tx_busy drops 16 clk later.
REQ-037 Send tx_data=4'b0111 -> P=1; the line reads 0,0,1,1,1,1,1.
REQ-038 Send 4'b0111 with parity_inv=1 -> P=0; a loopback receiver flags a parity error.
REQ-039 Pulse tx_req with 4'b0001 during the DATA state of a frame -> the request is ignored and no second frame is sent.
REQ-040 Hold tx_req high with tx_data=4'hF -> frames repeat with exactly 16 clk of high line between the stop-bit end and the next start bit.
REQ-041 Assert rst_n=0 during bit d1 -> fiber_tx=1 and tx_busy=0 immediately; no tx_done pulse occurs.
